// File: rtl/fetch_pkg.sv
// -----------------------------------------------------------------------------
// fetch_pkg
// Shared types and constants for the instruction-fetch stage.
//   fetch_entry_t : one prefetch FIFO entry {instr, pc} at the default 32/32
//                   widths (fetch_unit builds the same layout at its own widths)
//   fetch_state_e : fetch sequencer states
//   INSTR_BYTES   : PC increment per instruction
// -----------------------------------------------------------------------------
package fetch_pkg;

  localparam int FETCH_ADDR_WIDTH  = 32;
  localparam int FETCH_INSTR_WIDTH = 32;
  localparam int INSTR_BYTES       = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } fetch_state_e;

  typedef struct packed {
    logic [FETCH_INSTR_WIDTH-1:0] instr;
    logic [FETCH_ADDR_WIDTH-1:0]  pc;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// -----------------------------------------------------------------------------
// fetch_fifo
// Synchronous prefetch FIFO of fetch entries with flush.
//   clk, rst_n     : clock, asynchronous active-low reset
//   push, wdata    : write request and entry
//   pop            : remove head (ignored when empty)
//   flush          : discard all entries; wins over a push in the same cycle
//   rdata          : head entry (undefined when empty)
//   count          : number of stored entries
//   full, empty    : occupancy flags
// DEPTH must be a power of two so the pointers wrap naturally.
// -----------------------------------------------------------------------------
module fetch_fifo
  import fetch_pkg::*;
#(
  parameter int  DEPTH   = 4,
  parameter type entry_t = fetch_entry_t
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   push,
  input  entry_t                 wdata,
  input  logic                   pop,
  input  logic                   flush,
  output entry_t                 rdata,
  output logic [$clog2(DEPTH):0] count,
  output logic                   full,
  output logic                   empty
);

  localparam int PTR_W = $clog2(DEPTH);

  typedef logic [PTR_W-1:0] ptr_t;
  typedef logic [PTR_W:0]   cnt_t;

  localparam cnt_t DEPTH_CNT = cnt_t'(DEPTH);

  entry_t mem [DEPTH];
  ptr_t   wr_ptr;
  ptr_t   rd_ptr;
  logic   do_push;
  logic   do_pop;

  assign empty   = (count == '0);
  assign full    = (count == DEPTH_CNT);
  assign do_pop  = pop && !empty;
  // A push into a full FIFO is accepted only when the head leaves in the same cycle.
  assign do_push = push && (!full || do_pop);
  assign rdata   = mem[rd_ptr];

  // NOTE: sequential state is assigned with <= so every register samples the
  // values from before the edge, independent of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + ptr_t'(1);
      if (do_pop)  rd_ptr <= rd_ptr + ptr_t'(1);
      count <= count + cnt_t'(do_push) - cnt_t'(do_pop);
    end
  end

  // NOTE: the storage array has no reset; validity is tracked by count alone,
  // so clearing the data would only cost a reset net on every bit.
  always_ff @(posedge clk) begin
    if (do_push && !flush) mem[wr_ptr] <= wdata;
  end

endmodule

// File: rtl/fetch_unit.sv
// -----------------------------------------------------------------------------
// fetch_unit
// Instruction-fetch stage: issues sequential word-aligned fetches over a
// valid/ready channel, buffers in-order responses in a prefetch FIFO and hands
// {instr, pc} to decode. A redirect flushes wrong-path work and restarts at
// the new PC; responses still in flight are counted down and dropped.
//
// Ports
//   clk_i, rst_i        : clock, asynchronous active-low reset
//   imem_req_o/addr_o   : fetch request valid and word address
//   imem_gnt_i          : request accepted
//   imem_rvalid_i/rdata : in-order, non-stallable response
//   redirect_i/pc_i     : single-cycle restart pulse and target (bits [1:0] ignored)
//   instr_valid_o       : head entry valid
//   instr_ready_i       : decode takes the head
//   instr_o, instr_pc_o : head instruction and its PC (zero when not valid)
//
// Build option
//   FETCH_BYPASS_EN : when defined, a response arriving into an empty FIFO
//                     with nothing to drop is presented to decode in the same
//                     cycle, and skips the FIFO if decode takes it.
// -----------------------------------------------------------------------------
module fetch_unit
  import fetch_pkg::*;
#(
  parameter int                    ADDR_WIDTH  = 32,
  parameter int                    INSTR_WIDTH = 32,
  parameter int                    FIFO_DEPTH  = 4,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC    = '0
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  output logic                   imem_req_o,
  output logic [ADDR_WIDTH-1:0]  imem_addr_o,
  input  logic                   imem_gnt_i,
  input  logic                   imem_rvalid_i,
  input  logic [INSTR_WIDTH-1:0] imem_rdata_i,
  input  logic                   redirect_i,
  input  logic [ADDR_WIDTH-1:0]  redirect_pc_i,
  output logic                   instr_valid_o,
  input  logic                   instr_ready_i,
  output logic [INSTR_WIDTH-1:0] instr_o,
  output logic [ADDR_WIDTH-1:0]  instr_pc_o
);

  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

  localparam logic [ADDR_WIDTH-1:0] PC_STEP    = ADDR_WIDTH'(INSTR_BYTES);
  localparam logic [ADDR_WIDTH-1:0] ALIGN_MASK = ~ADDR_WIDTH'(INSTR_BYTES - 1);

  typedef logic [CNT_W-1:0] cnt_t;

  // Same layout as fetch_entry_t, sized by this instance's parameters.
  typedef struct packed {
    logic [INSTR_WIDTH-1:0] instr;
    logic [ADDR_WIDTH-1:0]  pc;
  } entry_t;

  fetch_state_e          state;
  logic [ADDR_WIDTH-1:0] fetch_pc;
  logic [ADDR_WIDTH-1:0] resp_pc;
  logic [ADDR_WIDTH-1:0] redirect_target;
  cnt_t                  outstanding;
  cnt_t                  drop_cnt;
  cnt_t                  drop_next;
  cnt_t                  outstanding_after;
  cnt_t                  issue_cnt;
  cnt_t                  rvalid_cnt;
  cnt_t                  fifo_count;
  logic                  issue;
  logic                  resp_accept;
  logic                  fifo_push;
  logic                  fifo_pop;
  logic                  fifo_full;
  logic                  fifo_empty;
  entry_t                resp_entry;
  entry_t                fifo_head;
  entry_t                head;

  assign redirect_target = redirect_pc_i & ALIGN_MASK;

  // Credit rule: buffered plus in-flight never exceeds the FIFO depth, which
  // is what lets responses arrive without backpressure.
  assign imem_req_o  = (state == RUN) && !redirect_i && !fifo_full &&
                       ((int'(fifo_count) + int'(outstanding)) < FIFO_DEPTH);
  assign imem_addr_o = fetch_pc;

  assign issue             = imem_req_o && imem_gnt_i;
  assign issue_cnt         = cnt_t'(issue);
  assign rvalid_cnt        = cnt_t'(imem_rvalid_i);
  assign outstanding_after = outstanding - rvalid_cnt;

  // A response is kept only on the correct path: nothing left to drop and no
  // redirect killing it in this very cycle.
  assign resp_accept = imem_rvalid_i && !redirect_i && (drop_cnt == '0);
  assign resp_entry  = '{instr: imem_rdata_i, pc: resp_pc};

  // Responses to drop: on a redirect, everything still in flight once this
  // cycle's response (itself discarded) has been counted.
  // NOTE: combinational blocks assign a default first so no path leaves the
  // output unassigned, which would infer a latch.
  always_comb begin
    drop_next = drop_cnt;
    if (redirect_i) begin
      drop_next = outstanding_after;
    end else if (imem_rvalid_i && (drop_cnt != '0)) begin
      drop_next = drop_cnt - cnt_t'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state       <= IDLE;
      fetch_pc    <= RESET_PC;
      resp_pc     <= RESET_PC;
      outstanding <= '0;
      drop_cnt    <= '0;
    end else begin
      outstanding <= outstanding + issue_cnt - rvalid_cnt;
      drop_cnt    <= drop_next;

      if (redirect_i) begin
        fetch_pc <= redirect_target;
        resp_pc  <= redirect_target;
      end else begin
        if (issue)       fetch_pc <= fetch_pc + PC_STEP;
        if (resp_accept) resp_pc  <= resp_pc + PC_STEP;
      end

      case (state)
        IDLE:    state <= RUN;
        RUN:     if (redirect_i && (outstanding_after != '0)) state <= DRAIN;
        // Leaves as soon as the last stale response is seen, even if a second
        // redirect arrives meanwhile; a redirect that finds nothing in flight
        // also lands back in RUN.
        DRAIN:   if (drop_next == '0) state <= RUN;
        default: state <= IDLE;
      endcase
    end
  end

  // Only a real head leaves the FIFO; the redirect flush leaves a same-cycle
  // pop intact because the head is read before the edge.
  assign fifo_pop = !fifo_empty && instr_ready_i;

`ifdef FETCH_BYPASS_EN
  logic bypass;

  assign bypass        = fifo_empty && resp_accept;
  assign fifo_push     = resp_accept && !(bypass && instr_ready_i);
  assign instr_valid_o = !fifo_empty || bypass;
  assign head          = fifo_empty ? resp_entry : fifo_head;
`else
  assign fifo_push     = resp_accept;
  assign instr_valid_o = !fifo_empty;
  assign head          = fifo_head;
`endif

  // Gate the head so decode sees zeros instead of stale storage when idle.
  assign instr_o    = instr_valid_o ? head.instr : '0;
  assign instr_pc_o = instr_valid_o ? head.pc    : '0;

  fetch_fifo #(
    .DEPTH   (FIFO_DEPTH),
    .entry_t (entry_t)
  ) u_fifo (
    .clk   (clk_i),
    .rst_n (rst_i),
    .push  (fifo_push),
    .wdata (resp_entry),
    .pop   (fifo_pop),
    .flush (redirect_i),
    .rdata (fifo_head),
    .count (fifo_count),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

endmodule

// File: tb/tb_fetch_unit.sv
// -----------------------------------------------------------------------------
// tb_fetch_unit
// Self-checking bench for fetch_unit. An instruction memory model answers
// every granted request in order after a chosen latency with a word derived
// from its address. The reference model is the architectural contract: the
// granted addresses form a +4 sequence restarted by each redirect, and the
// delivered stream is exactly that program order with the matching words,
// restarting at each redirect target after any same-cycle pop.
// Honours FETCH_BYPASS_EN for the expected delivery latency.
// -----------------------------------------------------------------------------
module tb_fetch_unit;
  import fetch_pkg::*;

  localparam int          AW     = 32;
  localparam int          IW     = 32;
  localparam int          DEPTH  = 4;
  localparam logic [31:0] RST_PC = 32'h0000_0000;

`ifdef FETCH_BYPASS_EN
  localparam int RESP_TO_USE = 0;
`else
  localparam int RESP_TO_USE = 1;
`endif

  logic          clk_i = 1'b0;
  logic          rst_i;
  logic          imem_req_o;
  logic [AW-1:0] imem_addr_o;
  logic          imem_gnt_i;
  logic          imem_rvalid_i;
  logic [IW-1:0] imem_rdata_i;
  logic          redirect_i;
  logic [AW-1:0] redirect_pc_i;
  logic          instr_valid_o;
  logic          instr_ready_i;
  logic [IW-1:0] instr_o;
  logic [AW-1:0] instr_pc_o;

  always #5 clk_i = ~clk_i;

  fetch_unit #(
    .ADDR_WIDTH  (AW),
    .INSTR_WIDTH (IW),
    .FIFO_DEPTH  (DEPTH),
    .RESET_PC    (RST_PC)
  ) dut (
    .clk_i         (clk_i),
    .rst_i         (rst_i),
    .imem_req_o    (imem_req_o),
    .imem_addr_o   (imem_addr_o),
    .imem_gnt_i    (imem_gnt_i),
    .imem_rvalid_i (imem_rvalid_i),
    .imem_rdata_i  (imem_rdata_i),
    .redirect_i    (redirect_i),
    .redirect_pc_i (redirect_pc_i),
    .instr_valid_o (instr_valid_o),
    .instr_ready_i (instr_ready_i),
    .instr_o       (instr_o),
    .instr_pc_o    (instr_pc_o)
  );

  typedef struct {
    logic [31:0] addr;
    int          due;
  } pend_t;

  pend_t       pend[$];
  logic [31:0] g_addr[$];
  int          g_cyc[$];
  logic [31:0] d_pc[$];
  int          d_cyc[$];

  int          cyc;
  int          lat;
  int          n_checks;
  int          n_errors;
  logic [31:0] exp_req_pc;
  logic [31:0] exp_del_pc;

  // Odd multiplier makes the address-to-word mapping a bijection.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_C3C3;
  endfunction

  function automatic logic [31:0] at_addr(input logic [31:0] q[$], input int i);
    if (i >= 0 && i < q.size()) return q[i];
    return 'x;
  endfunction

  function automatic logic [31:0] at_int(input int q[$], input int i);
    if (i >= 0 && i < q.size()) return 32'(q[i]);
    return 'x;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    n_checks++;
    assert (obs === expv) else begin
      n_errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, expv);
    end
  endtask

  // One clock cycle: drive the memory response, sample at the falling edge,
  // score handshakes against the model, then advance past the rising edge.
  task automatic step();
    logic g;
    logic p;
    if (pend.size() > 0 && pend[0].due <= cyc) begin
      imem_rvalid_i = 1'b1;
      imem_rdata_i  = mem_word(pend[0].addr);
      void'(pend.pop_front());
    end else begin
      imem_rvalid_i = 1'b0;
      imem_rdata_i  = $urandom;
    end
    @(negedge clk_i);
    g = imem_req_o & imem_gnt_i;
    p = instr_valid_o & instr_ready_i;
    if (redirect_i) chk("no_req_on_redirect", 64'(imem_req_o), 64'd0);
    if (g === 1'b1) begin
      chk("req_addr", 64'(imem_addr_o), 64'(exp_req_pc));
      g_addr.push_back(imem_addr_o);
      g_cyc.push_back(cyc);
      pend.push_back('{addr: imem_addr_o, due: cyc + lat});
      exp_req_pc = exp_req_pc + 32'd4;
    end
    if (p === 1'b1) begin
      chk("deliver_pc", 64'(instr_pc_o), 64'(exp_del_pc));
      chk("deliver_instr", 64'(instr_o), 64'(mem_word(exp_del_pc)));
      d_pc.push_back(instr_pc_o);
      d_cyc.push_back(cyc);
      exp_del_pc = exp_del_pc + 32'd4;
    end
    if (redirect_i) begin
      exp_req_pc = redirect_pc_i & ~32'h3;
      exp_del_pc = redirect_pc_i & ~32'h3;
    end
    @(posedge clk_i);
    #1;
    redirect_i = 1'b0;
    cyc++;
  endtask

  task automatic do_reset();
    rst_i         = 1'b0;
    imem_gnt_i    = 1'b0;
    imem_rvalid_i = 1'b0;
    imem_rdata_i  = '0;
    redirect_i    = 1'b0;
    redirect_pc_i = '0;
    instr_ready_i = 1'b0;
    pend.delete();
    g_addr.delete();
    g_cyc.delete();
    d_pc.delete();
    d_cyc.delete();
    repeat (2) @(posedge clk_i);
    #1;
    chk("reset_req", 64'(imem_req_o), 64'd0);
    chk("reset_valid", 64'(instr_valid_o), 64'd0);
    chk("reset_instr", 64'(instr_o), 64'd0);
    chk("reset_pc", 64'(instr_pc_o), 64'd0);
    chk("reset_state", 64'(dut.state), 64'(IDLE));
    rst_i      = 1'b1;
    cyc        = 0;
    exp_req_pc = RST_PC;
    exp_del_pc = RST_PC;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int n;
    int m;
    n_checks = 0;
    n_errors = 0;
    lat      = 1;

    // Streaming: back-to-back requests and in-order delivery.
    do_reset();
    imem_gnt_i = 1'b1; instr_ready_i = 1'b1; lat = 1;
    repeat (8) step();
    chk("t1_addr0", 64'(at_addr(g_addr, 0)), 64'h0);
    chk("t1_addr1", 64'(at_addr(g_addr, 1)), 64'h4);
    chk("t1_addr2", 64'(at_addr(g_addr, 2)), 64'h8);
    chk("t1_first_req_cyc", 64'(at_int(g_cyc, 0)), 64'd1);
    chk("t1_third_req_cyc", 64'(at_int(g_cyc, 2)), 64'd3);
    chk("t1_first_del_cyc", 64'(at_int(d_cyc, 0)), 64'(2 + RESP_TO_USE));
    chk("t1_del2_pc", 64'(at_addr(d_pc, 2)), 64'h8);

    // Decode stalled: credits cap requests at the FIFO depth.
    do_reset();
    imem_gnt_i = 1'b1; instr_ready_i = 1'b0; lat = 1;
    repeat (8) step();
    chk("t2_grants_full", 64'(g_addr.size()), 64'd4);
    chk("t2_req_low", 64'(imem_req_o), 64'd0);
    chk("t2_head_valid", 64'(instr_valid_o), 64'd1);
    instr_ready_i = 1'b1;
    step();
    instr_ready_i = 1'b0;
    chk("t2_pop_pc", 64'(at_addr(d_pc, 0)), 64'h0);
    repeat (3) step();
    chk("t2_grants_after_pop", 64'(g_addr.size()), 64'd5);
    chk("t2_new_addr", 64'(at_addr(g_addr, 4)), 64'h10);
    chk("t2_req_low_again", 64'(imem_req_o), 64'd0);

    // Redirect with two responses in flight: drain, then restart.
    do_reset();
    imem_gnt_i = 1'b1; instr_ready_i = 1'b1; lat = 6;
    repeat (3) step();
    imem_gnt_i = 1'b0; redirect_i = 1'b1; redirect_pc_i = 32'h100;
    step();
    chk("t3_state_drain", 64'(dut.state), 64'(DRAIN));
    imem_gnt_i = 1'b1; lat = 1;
    for (int i = 0; i < 20 && pend.size() > 0; i++) begin
      chk("t3_drain_req", 64'(imem_req_o), 64'd0);
      chk("t3_drain_valid", 64'(instr_valid_o), 64'd0);
      step();
    end
    chk("t3_drained", 64'(pend.size()), 64'd0);
    chk("t3_state_run", 64'(dut.state), 64'(RUN));
    chk("t3_fifo_empty", 64'(instr_valid_o), 64'd0);
    repeat (4) step();
    chk("t3_first_req", 64'(at_addr(g_addr, 2)), 64'h100);
    chk("t3_first_del", 64'(at_addr(d_pc, 0)), 64'h100);

    // Redirect coinciding with a response and a pop.
    do_reset();
    imem_gnt_i = 1'b1; instr_ready_i = 1'b0; lat = 1;
    repeat (4) step();
    chk("t4_head_valid", 64'(instr_valid_o), 64'd1);
    instr_ready_i = 1'b1; redirect_i = 1'b1; redirect_pc_i = 32'h200;
    step();
    chk("t4_popped_pc", 64'(at_addr(d_pc, 0)), 64'h0);
    chk("t4_popped_cyc", 64'(at_int(d_cyc, 0)), 64'd4);
    repeat (6) step();
    chk("t4_next_pc", 64'(at_addr(d_pc, 1)), 64'h200);

    // Grant withheld: request and address hold steady.
    do_reset();
    imem_gnt_i = 1'b0; instr_ready_i = 1'b1; lat = 1;
    step();
    for (int i = 0; i < 5; i++) begin
      chk("t5_req_held", 64'(imem_req_o), 64'd1);
      chk("t5_addr_held", 64'(imem_addr_o), 64'(RST_PC));
      step();
    end
    imem_gnt_i = 1'b1;
    step();
    chk("t5_one_grant", 64'(g_addr.size()), 64'd1);
    chk("t5_addr_next", 64'(imem_addr_o), 64'(RST_PC + 32'd4));

    // Address wrap, unaligned target, and delivery latency.
    do_reset();
    imem_gnt_i = 1'b1; instr_ready_i = 1'b1; lat = 1;
    repeat (3) step();
    n = g_addr.size();
    redirect_i = 1'b1; redirect_pc_i = 32'hFFFF_FFFF;
    step();
    m = d_pc.size();
    chk("t6_no_grant_redirect", 64'(g_addr.size()), 64'(n));
    repeat (5) step();
    chk("t6_addr_top", 64'(at_addr(g_addr, n)), 64'hFFFF_FFFC);
    chk("t6_addr_wrap", 64'(at_addr(g_addr, n + 1)), 64'h0);
    chk("t6_del_top", 64'(at_addr(d_pc, m)), 64'hFFFF_FFFC);
    chk("t6_del_wrap", 64'(at_addr(d_pc, m + 1)), 64'h0);
    chk("t6_latency", 64'(at_int(d_cyc, m) - at_int(g_cyc, n)), 64'(1 + RESP_TO_USE));

    // Randomised traffic against the reference model.
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      imem_gnt_i    = (($urandom % 4) != 0);
      instr_ready_i = (($urandom % 3) != 0);
      lat           = 1 + int'($urandom % 4);
      if (($urandom % 20) == 0) begin
        redirect_i    = 1'b1;
        redirect_pc_i = (($urandom % 4) == 0) ? (32'hFFFF_FFF0 | ($urandom % 16)) : $urandom;
      end
      step();
    end
    chk("rand_progress", 64'(d_pc.size() > 200), 64'd1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
